// File: rtl/cordic_pkg.sv
// Shared types and constants for the time-shared CORDIC arctangent engine.
// Angles and operands are signed fixed point with FRAC fractional bits.
package cordic_pkg;

  localparam int DW        = 20;
  localparam int FRAC      = 4;
  localparam int LUT_DEPTH = 12;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    RESP
  } state_t;

  // atan(2^-i) in degrees, Q16.4; zero past the last tabulated micro-rotation.
  function automatic logic signed [DW-1:0] atan_lut(input logic [3:0] i);
    case (i)
      4'd0:    return 20'sd720;
      4'd1:    return 20'sd425;
      4'd2:    return 20'sd225;
      4'd3:    return 20'sd114;
      4'd4:    return 20'sd57;
      4'd5:    return 20'sd29;
      4'd6:    return 20'sd14;
      4'd7:    return 20'sd7;
      4'd8:    return 20'sd4;
      4'd9:    return 20'sd2;
      4'd10:   return 20'sd1;
      default: return 20'sd0;
    endcase
  endfunction

endpackage

// File: rtl/cordic_atan_scheduler_if.sv
// Request/response bundle between the sweep clients and the shared CORDIC engine.
// The master side belongs to the clients, the slave side to the scheduler.
interface cordic_atan_scheduler_if
  import cordic_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DW      = cordic_pkg::DW
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*DW-1:0] req_y;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  rsp_valid;
  logic [IW-1:0]         rsp_id;
  logic signed [DW-1:0]  rsp_z;
  logic                  rsp_ready;
  logic                  busy;

  modport master (
    output req_valid, req_y, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_z, busy
  );

  modport slave (
    input  req_valid, req_y, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_z, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching upward from the
// pointer; the pointer moves just past the winner when advance is pulsed.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);
  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] idx;
  logic          found;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave a value held and infer a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    found     = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr_q) + i) % N);
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
    if (found) grant[grant_idx] = 1'b1;
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (grant_idx == PW'(N - 1)) ? '0 : grant_idx + PW'(1);
    end
  end

endmodule

// File: rtl/cordic_atan_scheduler.sv
// One iterative CORDIC vectoring engine shared round-robin among NUM_REQ
// clients; returns atan(y / X_CONST) in degrees (Q16.4) tagged with the client id.
module cordic_atan_scheduler
  import cordic_pkg::*;
#(
  parameter int                   NUM_REQ = 4,
  parameter int                   DW      = cordic_pkg::DW,
  parameter int                   ITER    = 12,
  parameter logic signed [DW-1:0] X_CONST = 20'sd16
) (
  input  logic                    clk,
  input  logic                    rst,
  cordic_atan_scheduler_if.slave  bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = 4;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant;
  logic [IW-1:0]        grant_idx;
  logic [IW-1:0]        id_q;
  logic                 accept;
  logic                 last;
  logic [CW-1:0]        cnt_q;
  logic signed [DW-1:0] sel_y;
  logic signed [DW-1:0] x_q, y_q, z_q;
  logic signed [DW-1:0] x_nx, y_nx, z_nx;
  logic signed [DW-1:0] x_sh, y_sh, ang;
  logic signed [DW-1:0] rsp_z_q;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.req_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign bus.req_ready = (state_q == IDLE) ? grant : '0;
  assign accept        = |(bus.req_valid & bus.req_ready);
  assign last          = (cnt_q == CW'(ITER - 1));
  assign sel_y         = bus.req_y[int'(grant_idx)*DW +: DW];

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_z     = rsp_z_q;
  assign bus.busy      = (state_q != IDLE);

  // The ITER parameter shadows the enum label, so that state is package-qualified.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:             if (accept)        state_d = cordic_pkg::ITER;
      cordic_pkg::ITER: if (last)          state_d = RESP;
      RESP:             if (bus.rsp_ready) state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  // Vectoring micro-rotation: drive y toward zero, accumulating the angle in z.
  always_comb begin
    x_sh = x_q >>> cnt_q;
    y_sh = y_q >>> cnt_q;
    ang  = DW'(atan_lut(cnt_q));
    if (!y_q[DW-1]) begin
      x_nx = x_q + y_sh;
      y_nx = y_q - x_sh;
      z_nx = z_q + ang;
    end else begin
      x_nx = x_q - y_sh;
      y_nx = y_q + x_sh;
      z_nx = z_q - ang;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
      rsp_z_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            x_q   <= X_CONST;
            y_q   <= sel_y;
            z_q   <= '0;
            cnt_q <= '0;
            id_q  <= grant_idx;
          end
        end
        cordic_pkg::ITER: begin
          x_q <= x_nx;
          y_q <= y_nx;
          z_q <= z_nx;
          if (last) rsp_z_q <= z_nx;
          else      cnt_q   <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_atan_scheduler.sv
// Directed and randomized checks of the shared CORDIC scheduler against an
// integer model of the fixed-point rotation rules and the round-robin policy.
module tb_cordic_atan_scheduler;
  localparam int NUM_REQ = 4;
  localparam int DW      = 20;
  localparam int ITER    = 12;
  localparam int LUT [12] = '{720, 425, 225, 114, 57, 29, 14, 7, 4, 2, 1, 0};

  logic clk = 1'b0;
  logic rst;
  int   tests  = 0;
  int   failed = 0;

  cordic_atan_scheduler_if #(.NUM_REQ(NUM_REQ), .DW(DW)) bus ();

  cordic_atan_scheduler #(.NUM_REQ(NUM_REQ), .DW(DW), .ITER(ITER)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic int wrap(input int v);
    logic signed [DW-1:0] t;
    t = v[DW-1:0];
    return int'(t);
  endfunction

  // Angle the engine should report for y, following the fixed-point rules exactly.
  function automatic int cordic_ref(input int y_in);
    int x, y, z, xs, ys;
    x = 16; y = y_in; z = 0;
    for (int i = 0; i < ITER; i++) begin
      xs = x >>> i;
      ys = y >>> i;
      if (y >= 0) begin
        x = wrap(x + ys); y = wrap(y - xs); z = wrap(z + LUT[i]);
      end else begin
        x = wrap(x - ys); y = wrap(y + xs); z = wrap(z - LUT[i]);
      end
    end
    return z;
  endfunction

  function automatic int idx_of(input logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Counts rising edges after an accept until rsp_valid appears (bounded).
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic single(input int k, input int y, input string tag);
    int lat;
    int exp_z;
    exp_z = cordic_ref(y);
    @(negedge clk);
    bus.req_y = '0;
    bus.req_y[k*DW +: DW] = y[DW-1:0];
    bus.req_valid = NUM_REQ'(1) << k;
    #1 check({tag, "_ready"}, 32'(bus.req_ready), 32'(NUM_REQ'(1) << k));
    @(posedge clk); #1;
    bus.req_valid = '0;
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    wait_rsp(lat);
    check({tag, "_lat"}, lat, ITER);
    check({tag, "_id"}, 32'(bus.rsp_id), k);
    check({tag, "_z"}, bus.rsp_z, exp_z);
    @(posedge clk); #1;
    check({tag, "_drop"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    int lat, cyc, last_cyc, n_acc, n_rsp, rises, k, y;
    int fy [NUM_REQ];
    int acc_q [$];

    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_y     = '0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("rst_valid", 32'(bus.rsp_valid), 0);
    check("rst_z", bus.rsp_z, 0);
    check("rst_id", 32'(bus.rsp_id), 0);
    check("rst_busy", 32'(bus.busy), 0);
    @(negedge clk); rst = 1'b0;

    single(2, 16, "one");
    single(0, 0, "zero");
    single(1, -16, "neg1");
    single(3, 480, "p30");
    single(2, -480, "n30");
    single(0, 131072, "ymax");
    single(3, -131072, "ymin");

    for (int n = 0; n < 16; n++) begin
      k = int'($urandom_range(0, NUM_REQ - 1));
      y = int'($urandom_range(0, 262144)) - 131072;
      single(k, y, "rand");
    end

    for (int v = -30; v <= 30; v++) single(1, v, "sweep");

    // Backpressure with a competing request pending.
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    bus.req_y = '0;
    bus.req_y[3*DW +: DW] = 20'sd200;
    bus.req_y[0*DW +: DW] = -20'sd100;
    bus.req_valid = 4'b1000;
    @(posedge clk); #1;
    bus.req_valid = 4'b0001;
    wait_rsp(lat);
    check("bp_lat", lat, ITER);
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      check("bp_valid", 32'(bus.rsp_valid), 1);
      check("bp_id", 32'(bus.rsp_id), 3);
      check("bp_z", bus.rsp_z, cordic_ref(200));
      check("bp_ready", 32'(bus.req_ready), 0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_hs_drop", 32'(bus.rsp_valid), 0);
    check("bp_next_grant", 32'(bus.req_ready), 32'b0001);
    @(posedge clk); #1;
    bus.req_valid = '0;
    check("bp_next_busy", 32'(bus.busy), 1);
    wait_rsp(lat);
    check("bp_next_lat", lat, ITER);
    check("bp_next_id", 32'(bus.rsp_id), 0);
    check("bp_next_z", bus.rsp_z, cordic_ref(-100));
    @(posedge clk); #1;

    // Asynchronous reset while rotating: outputs clear with no clock edge.
    @(negedge clk);
    bus.req_y[1*DW +: DW] = 20'sd77;
    bus.req_valid = 4'b0010;
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_iter_valid", 32'(bus.rsp_valid), 0);
    check("arst_iter_z", bus.rsp_z, 0);
    check("arst_iter_id", 32'(bus.rsp_id), 0);
    check("arst_iter_busy", 32'(bus.busy), 0);
    @(negedge clk); rst = 1'b0;
    rises = 0;
    repeat (20) begin @(posedge clk); #1; if (bus.rsp_valid) rises++; end
    check("arst_iter_norsp", rises, 0);

    // Asynchronous reset while a response is stalled.
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    bus.req_y[2*DW +: DW] = -20'sd300;
    bus.req_valid = 4'b0100;
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_rsp(lat);
    check("arst_resp_lat", lat, ITER);
    #3 rst = 1'b1;
    #1;
    check("arst_resp_valid", 32'(bus.rsp_valid), 0);
    check("arst_resp_z", bus.rsp_z, 0);
    check("arst_resp_busy", 32'(bus.busy), 0);
    @(negedge clk); rst = 1'b0;
    rises = 0;
    repeat (20) begin @(posedge clk); #1; if (bus.rsp_valid) rises++; end
    check("arst_resp_norsp", rises, 0);
    bus.rsp_ready = 1'b1;

    // All clients valid after reset: strict rotation starting at 0.
    fy = '{16, -48, 300, -1000};
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) bus.req_y[i*DW +: DW] = fy[i][DW-1:0];
    bus.req_valid = '1;
    n_acc = 0; n_rsp = 0; cyc = 0; last_cyc = 0;
    while (n_rsp < 5 && cyc < 200) begin
      if (cyc > 0) @(negedge clk);
      #1;
      cyc++;
      if (bus.req_ready != '0 && n_acc < 5) begin
        check("fair_order", idx_of(bus.req_ready), n_acc % NUM_REQ);
        if (n_acc > 0) check("fair_spacing", cyc - last_cyc, ITER + 2);
        last_cyc = cyc;
        acc_q.push_back(idx_of(bus.req_ready));
        n_acc++;
        if (n_acc == 5) begin @(posedge clk); #1; bus.req_valid = '0; end
      end
      if (bus.rsp_valid && n_rsp < acc_q.size()) begin
        check("fair_id", 32'(bus.rsp_id), acc_q[n_rsp]);
        check("fair_z", bus.rsp_z, cordic_ref(fy[acc_q[n_rsp]]));
        n_rsp++;
      end
    end
    check("fair_done", n_rsp, 5);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
